mmio_sw_led: RTL
================

Name: mmio_sw_led

Overview:
- Memory-mapped I/O responder that sits between the processor's data-memory port and the board switches (SW) and red LEDs (LEDR).
- Synchronizes and debounces the switch inputs and records switch changes in sticky bits.
- Holds the LED output register, which software drives with direct, set and clear writes.
- Answers processor loads and stores that fall in its address window; all other addresses are ignored so data memory can respond.

Parameters:
BASE_ADDR, 16'hC000, first address of the 8-word register window (bits [2:0] must be 0)
NUM_IO, 10, number of switches and LEDs (1..16)
DEBOUNCE_CYCLES, 4, clock cycles between debounce samples (>=1)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
addr  input  16  processor data address
re  input  1  read strobe, one cycle per access
we  input  1  write strobe, one cycle per access
wdata  input  16  store data
rdata  output  16  load data, valid the cycle after a hit read
rvalid  output  1  one-cycle pulse qualifying rdata
hit  output  1  combinational: addr is in [BASE_ADDR, BASE_ADDR+7] and (re or we)
SW  input  NUM_IO  raw asynchronous switch inputs
LEDR  output  NUM_IO  LED drive, straight from the LED register
sw_irq  output  1  OR of all sticky change bits

Behaviour:
- Reset is asynchronous, active-low. It clears to 0: LED register, LEDR, rdata, rvalid, both synchronizer stages, debounced value, candidate sample, tick counter, sticky change bits and sw_irq.
- Register map, by offset = addr[2:0]:
  - 0 SW_VAL (RO): debounced switch value.
  - 1 LED (RW): write replaces the LED register.
  - 2 LED_SET (W): LED |= wdata. Reads return LED.
  - 3 LED_CLR (W): LED &= ~wdata. Reads return LED.
  - 4 SW_CHG (R, clear-on-read): sticky change bits.
  - 5-7: reserved. Reads return 0; writes are ignored.
- Data widths: only bits [NUM_IO-1:0] of wdata are used. Read data is zero-extended to 16 bits.
- Write timing: the write takes effect at the clock edge where we=1 and hit=1. LEDR shows the new value the following cycle.
- Read timing: on a hit read (re=1), rdata is registered and rvalid=1 on the next cycle. Latency is exactly 1 cycle.
  - rvalid is 0 on every other cycle.
  - rdata holds its last value until the next hit read.
- re and we both high in the same cycle: the write is performed and the read is ignored (rvalid stays 0).
- A non-hit access has no effect on any register.
- Switch path:
  - Two-flop synchronizer on SW.
  - The tick counter counts 0..DEBOUNCE_CYCLES-1, wraps, and pulses tick when it wraps.
  - On each tick the synchronized value is compared with the candidate sample, then stored as the new candidate.
  - A bit of the debounced value updates only when its synchronized bit equals the candidate bit AND differs from the current debounced bit. Minimum acceptance time is therefore between DEBOUNCE_CYCLES+1 and 2*DEBOUNCE_CYCLES+2 cycles after SW changes.
  - A bit that toggles and returns before two agreeing ticks never changes the debounced value.
- Sticky change bits: a bit is set in the cycle its debounced bit updates, in either direction.
  - A hit read of SW_CHG returns the current bits and clears them at the same edge.
  - A change arriving in the same cycle as that read is kept: set wins over clear, and the bit reads 1 on the next read.
- sw_irq is registered: it is 1 exactly when any sticky change bit is 1.
- Reset asserted mid-access: everything clears at once; a read that is in flight produces no rvalid.

Test Plan:
- Reset: hold rst_n=0 with SW=10'h3FF and apply writes -> LEDR=0, rvalid=0, sw_irq=0. After release, read offset 0 -> 0 until the debounce window has passed.
- LED writes: write LED=16'h0005, then LED_SET=16'h0002, then LED_CLR=16'h0004 -> LEDR is 10'h005, 10'h007, 10'h003 on successive cycles after each write. Read offset 1 -> rdata=16'h0003 with rvalid high exactly one cycle later.
- Debounce and change tracking: with DEBOUNCE_CYCLES=4, set SW=10'h001 -> SW_VAL reads 16'h0001 within 10 cycles and sw_irq rises. Read SW_CHG -> 16'h0001. Read SW_CHG again -> 16'h0000, and sw_irq drops.
- Glitch rejection: pulse SW[1] high for 2 cycles -> SW_VAL stays 0, SW_CHG stays 0.
- Set-over-clear: time the read of SW_CHG to coincide with SW[2] being accepted -> that read returns the old bits, and the next read returns 16'h0004.
- Address decode: read BASE_ADDR+8 and BASE_ADDR-1, and write 16'hFFFF to BASE_ADDR+6 -> hit=0 or no effect, no rvalid, LEDR unchanged. A reserved in-window read returns 16'h0000 with rvalid.

Source files
------------

// File: rtl/mmio_sw_led.sv
// mmio_sw_led: memory-mapped responder for the board switches (synchronized,
// debounced, change-tracked) and the red LED output register.
module mmio_sw_led #(
    parameter logic [15:0] BASE_ADDR       = 16'hC000,
    parameter int          NUM_IO          = 10,
    parameter int          DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       addr,
    input  logic              re,
    input  logic              we,
    input  logic [15:0]       wdata,
    output logic [15:0]       rdata,
    output logic              rvalid,
    output logic              hit,
    input  logic [NUM_IO-1:0] SW,
    output logic [NUM_IO-1:0] LEDR,
    output logic              sw_irq
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [NUM_IO-1:0] led;
    logic [NUM_IO-1:0] sync1;
    logic [NUM_IO-1:0] sync2;
    logic [NUM_IO-1:0] cand;
    logic [NUM_IO-1:0] deb;
    logic [NUM_IO-1:0] chg;
    logic [NUM_IO-1:0] upd;
    logic [NUM_IO-1:0] chg_next;
    logic [NUM_IO-1:0] wd;
    logic [CW-1:0]     tick_cnt;
    logic              tick;
    logic              wr_hit;
    logic              rd_hit;
    logic              chg_clr;
    logic [2:0]        offset;
    logic [15:0]       rd_mux;
    logic              unused_wdata;

    assign offset       = addr[2:0];
    assign hit          = (addr[15:3] == BASE_ADDR[15:3]) && (re || we);
    assign wr_hit       = hit && we;
    assign rd_hit       = hit && re && !we;
    assign wd           = wdata[NUM_IO-1:0];
    assign unused_wdata = ^wdata;
    assign LEDR         = led;

    assign tick = (tick_cnt == TICK_LAST);
    // A bit is accepted when two consecutive tick samples agree and differ from deb
    assign upd  = tick ? (~(sync2 ^ cand) & (sync2 ^ deb)) : '0;

    // New changes are OR-ed in after the read-clear so a same-cycle change survives
    assign chg_clr  = rd_hit && (offset == 3'd4);
    assign chg_next = (chg_clr ? '0 : chg) | upd;

    always_comb begin
        rd_mux = '0;
        case (offset)
            3'd0:               rd_mux[NUM_IO-1:0] = deb;
            3'd1, 3'd2, 3'd3:   rd_mux[NUM_IO-1:0] = led;
            3'd4:               rd_mux[NUM_IO-1:0] = chg;
            default:            rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= '0;
            sync2    <= '0;
            cand     <= '0;
            deb      <= '0;
            tick_cnt <= '0;
            chg      <= '0;
            sw_irq   <= 1'b0;
        end else begin
            sync1    <= SW;
            sync2    <= sync1;
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (tick) begin
                cand <= sync2;
                deb  <= deb ^ upd;
            end
            chg    <= chg_next;
            sw_irq <= |chg_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led <= '0;
        end else if (wr_hit) begin
            case (offset)
                3'd1:    led <= wd;
                3'd2:    led <= led | wd;
                3'd3:    led <= led & ~wd;
                default: led <= led;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= rd_hit;
            if (rd_hit) begin
                rdata <= rd_mux;
            end
        end
    end
endmodule
